// File: rtl/loteria_pkg.sv
// Shared types and defaults for the lottery bet entry block and its downstream checker.
package loteria_pkg;

    localparam int DIGITO_W         = 4;
    localparam int DIGITOS_PADRAO   = 5;
    localparam int MAX_JOGOS_PADRAO = 5;
    localparam int JOGOS_W          = 3;

    typedef enum logic [1:0] {
        COLETA   = 2'd0,
        ENVIA    = 2'd1,
        FIM      = 2'd2,
        BLOQUEIO = 2'd3
    } estado_t;

    function automatic logic digito_valido(input logic [DIGITO_W-1:0] t);
        return (t <= DIGITO_W'(9));
    endfunction

endpackage

// File: rtl/loteria_entrada_if.sv
// Keypad-side strobes and checker-side outputs of the bet entry block.
interface loteria_entrada_if;
    import loteria_pkg::*;

    logic [DIGITO_W-1:0] tecla;
    logic                tecla_valida;
    logic                apaga;
    logic                confirma;
    logic [DIGITO_W-1:0] numero;
    logic                insere;
    logic                fim_jogo;
    logic                ocupado;
    logic                erro;
    logic [JOGOS_W-1:0]  jogos;
    logic                bloqueado;

    modport master (
        output tecla, tecla_valida, apaga, confirma,
        input  numero, insere, fim_jogo, ocupado, erro, jogos, bloqueado
    );

    modport slave (
        input  tecla, tecla_valida, apaga, confirma,
        output numero, insere, fim_jogo, ocupado, erro, jogos, bloqueado
    );

endinterface

// File: rtl/loteria_digito_buf.sv
// Digit register file with push/pop/clear on a fill count and an indexed read port.
module loteria_digito_buf
    import loteria_pkg::*;
#(
    parameter int DIGITOS = DIGITOS_PADRAO
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         push_i,
    input  logic                         pop_i,
    input  logic                         clear_i,
    input  logic [DIGITO_W-1:0]          dado_i,
    input  logic [$clog2(DIGITOS)-1:0]   rd_idx_i,
    output logic [DIGITO_W-1:0]          rd_dado_o,
    output logic [$clog2(DIGITOS+1)-1:0] qtd_o
);
    localparam int CNT_W = $clog2(DIGITOS + 1);
    localparam logic [CNT_W-1:0] CHEIO = CNT_W'(DIGITOS);

    logic [CNT_W-1:0]    qtd_q;
    logic [CNT_W-1:0]    qtd_d;
    logic [DIGITO_W-1:0] slot_w [DIGITOS];

    // Slot contents are not reset: a zero fill count already hides them.
    generate
        for (genvar gi = 0; gi < DIGITOS; gi++) begin : g_slot
            logic [DIGITO_W-1:0] dado_q;

            always_ff @(posedge clock) begin
                if (push_i && (qtd_q == CNT_W'(gi))) begin
                    dado_q <= dado_i;
                end
            end

            assign slot_w[gi] = dado_q;
        end
    endgenerate

    always_comb begin
        qtd_d = qtd_q;
        if (clear_i) begin
            qtd_d = '0;
        end else if (pop_i && (qtd_q != '0)) begin
            qtd_d = qtd_q - 1'b1;
        end else if (push_i && (qtd_q != CHEIO)) begin
            qtd_d = qtd_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            qtd_q <= '0;
        end else begin
            qtd_q <= qtd_d;
        end
    end

    assign rd_dado_o = slot_w[rd_idx_i];
    assign qtd_o     = qtd_q;

endmodule

// File: rtl/loteria_entrada.sv
// Keypad bet entry: collects DIGITOS digits, streams them to the checker and counts bets.
module loteria_entrada
    import loteria_pkg::*;
#(
    parameter int DIGITOS   = DIGITOS_PADRAO,
    parameter int MAX_JOGOS = MAX_JOGOS_PADRAO
) (
    input  logic             clock,
    input  logic             reset,
    loteria_entrada_if.slave bus
);
    localparam int CNT_W = $clog2(DIGITOS + 1);
    localparam int IDX_W = $clog2(DIGITOS);
    localparam logic [CNT_W-1:0]   CHEIO        = CNT_W'(DIGITOS);
    localparam logic [IDX_W-1:0]   ULTIMO_ENVIA = IDX_W'(DIGITOS - 2);
    localparam logic [JOGOS_W-1:0] LIMITE       = JOGOS_W'(MAX_JOGOS);

    estado_t             estado_q;
    logic [IDX_W-1:0]    idx_q;
    logic [DIGITO_W-1:0] numero_q;
    logic                insere_q;
    logic                fim_jogo_q;
    logic                ocupado_q;
    logic                erro_q;
    logic [JOGOS_W-1:0]  jogos_q;
    logic                bloqueado_q;

    logic [CNT_W-1:0]    qtd;
    logic [IDX_W-1:0]    rd_idx;
    logic [DIGITO_W-1:0] rd_dado;
    logic                push;
    logic                pop;
    logic                clear;
    logic                tecla_ok;
    logic                alguma_tecla;

    assign tecla_ok     = digito_valido(bus.tecla);
    assign alguma_tecla = bus.tecla_valida | bus.apaga | bus.confirma;

    // idx_q is the digit on numero now, so the read port looks one ahead;
    // from COLETA it points at digit 0 for the first streamed cycle.
    assign rd_idx = (estado_q == ENVIA) ? (idx_q + 1'b1) : '0;

    always_comb begin
        push  = 1'b0;
        pop   = 1'b0;
        clear = 1'b0;
        if (estado_q == COLETA) begin
            if (bus.apaga) begin
                pop = (qtd != '0);
            end else if (!bus.confirma && bus.tecla_valida) begin
                push = tecla_ok && (qtd != CHEIO);
            end
        end else if (estado_q == FIM) begin
            clear = 1'b1;
        end
    end

    loteria_digito_buf #(
        .DIGITOS (DIGITOS)
    ) u_buf (
        .clock     (clock),
        .reset     (reset),
        .push_i    (push),
        .pop_i     (pop),
        .clear_i   (clear),
        .dado_i    (bus.tecla),
        .rd_idx_i  (rd_idx),
        .rd_dado_o (rd_dado),
        .qtd_o     (qtd)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q    <= COLETA;
            idx_q       <= '0;
            numero_q    <= '0;
            insere_q    <= 1'b0;
            fim_jogo_q  <= 1'b0;
            ocupado_q   <= 1'b0;
            erro_q      <= 1'b0;
            jogos_q     <= '0;
            bloqueado_q <= 1'b0;
        end else begin
            erro_q <= 1'b0;
            case (estado_q)
                COLETA: begin
                    if (bus.apaga) begin
                        if (qtd == '0) erro_q <= 1'b1;
                    end else if (bus.confirma) begin
                        if (qtd == CHEIO) begin
                            estado_q  <= ENVIA;
                            idx_q     <= '0;
                            numero_q  <= rd_dado;
                            insere_q  <= 1'b1;
                            ocupado_q <= 1'b1;
                        end else begin
                            erro_q <= 1'b1;
                        end
                    end else if (bus.tecla_valida) begin
                        if (!tecla_ok || (qtd == CHEIO)) erro_q <= 1'b1;
                    end
                end
                ENVIA: begin
                    numero_q <= rd_dado;
                    if (idx_q == ULTIMO_ENVIA) begin
                        estado_q   <= FIM;
                        insere_q   <= 1'b0;
                        fim_jogo_q <= 1'b1;
                        if (jogos_q != LIMITE) jogos_q <= jogos_q + 1'b1;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                FIM: begin
                    numero_q   <= '0;
                    fim_jogo_q <= 1'b0;
                    ocupado_q  <= 1'b0;
                    idx_q      <= '0;
                    if (jogos_q == LIMITE) begin
                        estado_q    <= BLOQUEIO;
                        bloqueado_q <= 1'b1;
                    end else begin
                        estado_q <= COLETA;
                    end
                end
                BLOQUEIO: begin
                    erro_q <= alguma_tecla;
                end
                default: begin
                    estado_q <= COLETA;
                end
            endcase
        end
    end

    assign bus.numero    = numero_q;
    assign bus.insere    = insere_q;
    assign bus.fim_jogo  = fim_jogo_q;
    assign bus.ocupado   = ocupado_q;
    assign bus.erro      = erro_q;
    assign bus.jogos     = jogos_q;
    assign bus.bloqueado = bloqueado_q;

endmodule

// File: doc/loteria_entrada.md
LOTERIA_ENTRADA -- requirements
Module: loteria_entrada

Interface
REQ-001 SHALL have parameter DIGITOS, 5, digits per bet.
REQ-002 SHALL have parameter MAX_JOGOS, 5, bets accepted between resets.
REQ-003 SHALL have port clock  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port tecla  input  4  keypad digit value.
REQ-006 SHALL have port tecla_valida  input  1  one-cycle strobe; tecla valid this cycle.
REQ-007 SHALL have port apaga  input  1  one-cycle strobe; delete last buffered digit.
REQ-008 SHALL have port confirma  input  1  one-cycle strobe; submit buffered bet.
REQ-009 SHALL have port numero  output  4  digit presented to the downstream checker.
REQ-010 SHALL have port insere  output  1  numero carries a bet digit 0..DIGITOS-2 this cycle.
REQ-011 SHALL have port fim_jogo  output  1  one-cycle pulse; numero carries the final digit, bet complete.
REQ-012 SHALL have port ocupado  output  1  high while streaming; key inputs are ignored.
REQ-013 SHALL have port erro  output  1  one-cycle pulse on a rejected key action.
REQ-014 SHALL have port jogos  output  3  count of bets streamed since reset.
REQ-015 SHALL have port bloqueado  output  1  high once jogos == MAX_JOGOS.

Function
REQ-016 SHALL implement states COLETA, ENVIA, FIM and BLOQUEIO.
REQ-017 In COLETA, SHALL hold a digit buffer with index qtd in 0..DIGITOS.
REQ-018 In COLETA, SHALL resolve key strobes in the same cycle with priority apaga > confirma > tecla_valida; lower-priority strobes in that cycle are dropped silently.
REQ-019 On apaga with qtd>0, SHALL decrement qtd; with qtd==0, SHALL pulse erro.
REQ-020 On tecla_valida with tecla<=9 and qtd<DIGITOS, SHALL store tecla at index qtd and increment qtd.
REQ-021 On tecla_valida with tecla>9 or qtd==DIGITOS, SHALL pulse erro and leave the buffer unchanged.
REQ-022 On confirma with qtd<DIGITOS, SHALL pulse erro.
REQ-023 On confirma with qtd==DIGITOS, SHALL go to ENVIA next cycle with send index 0.
REQ-024 In ENVIA, SHALL drive insere=1 and numero=buffer[idx] for one cycle per digit, idx 0..DIGITOS-2, back-to-back, starting the cycle after confirma.
REQ-025 After idx DIGITOS-2, SHALL go to FIM.
REQ-026 In FIM, for exactly one cycle, SHALL drive insere=0, fim_jogo=1, numero=buffer[DIGITOS-1], and SHALL increment jogos.
REQ-027 After FIM, SHALL go to BLOQUEIO if the new jogos==MAX_JOGOS, else to COLETA with qtd=0.
REQ-028 SHALL drive ocupado=1 in ENVIA and FIM, and SHALL ignore all key strobes there without pulsing erro.
REQ-029 In BLOQUEIO, SHALL drive bloqueado=1, SHALL pulse erro on any key strobe, and SHALL leave BLOQUEIO only via reset.
REQ-030 When not in ENVIA or FIM, SHALL hold numero at 0 and insere and fim_jogo at 0.
REQ-031 erro SHALL be registered, asserting the cycle after the offending strobe.
REQ-032 All outputs SHALL be registered, with no combinational path from inputs to outputs.
REQ-033 jogos SHALL saturate at MAX_JOGOS and SHALL never wrap.

Reset
REQ-034 reset high at a rising edge SHALL force state COLETA, qtd=0, idx=0, jogos=0, numero=0, and insere=fim_jogo=ocupado=erro=bloqueado=0.
REQ-035 reset SHALL take priority over all other inputs, including mid-ENVIA, where streaming SHALL stop without a fim_jogo pulse.
REQ-036 Buffer contents need not be cleared by reset; qtd=0 makes them unreachable.

Structure
REQ-037 A shared package loteria_pkg SHALL hold the state enum, DIGITO_W=4, DIGITOS and MAX_JOGOS defaults, shared with the checker.
REQ-038 The digit buffer SHALL be a sub-module loteria_digito_buf (DIGITOS x 4 register file with push, pop, clear and indexed read), driven by the FSM in loteria_entrada.

Verification
REQ-039 Keys 5,3,8,2,0 then confirma -> next 4 cycles insere=1 with numero 5,3,8,2, then one cycle fim_jogo=1 with numero=0; jogos=1.
REQ-040 Keys 5,3,7, apaga, 8,2,0, confirma -> stream 5,3,8,2 then final digit 0; erro never asserted.
REQ-041 tecla=12 strobe, a 6th digit, and confirma with 4 digits -> erro pulses once each, buffer unchanged.
REQ-042 Five full bets -> bloqueado=1 after the 5th fim_jogo; a further key strobe pulses erro and produces no insere.
REQ-043 reset asserted on the 2nd ENVIA cycle -> next cycle all outputs 0, state COLETA, no fim_jogo.
REQ-044 apaga, confirma and tecla_valida in the same COLETA cycle with qtd=5 -> only the delete takes effect (qtd=4), no erro.
